sd_dat_xfer_ctrl: RTL and testbench
===================================

Name: sd_dat_xfer_ctrl

Overview:
Transaction sequencer for the SD host DAT physical layer.
- Accepts a block read/write request from the host register/DMA side.
- Configures dat_phys with direction, block count, multiple flag and timeout.
- Issues one strobe per block, gated on FIFO readiness.
- Counts completed blocks and reports done/error.
- Sits between host registers/FIFO and dat_phys in the SD clock domain.

Parameters:
BLK_W, 4, width of block count (matches dat_phys blocks port)
TMO_W, 16, width of timeout values (matches dat_phys TIMEOUT_REG)
MAX_RETRY, 2, retries per block; used only when SD_DAT_CTRL_RETRY_EN is defined

Ports:
sd_clock  in  1  SD clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse
write_read  in  1  1 = host-to-card write, 0 = card-to-host read; sampled on start
num_blocks  in  BLK_W  blocks to transfer; sampled on start
timeout_val  in  TMO_W  phy timeout and FIFO watchdog limit; sampled on start
fifo_ready  in  1  write: a full block is in the FIFO; read: a block of space is free
phy_complete  in  1  dat_phys one-cycle pulse: block finished, CRC ok
phy_error  in  1  dat_phys one-cycle pulse: CRC or timeout failure
phy_strobe  out  1  one-cycle start pulse to dat_phys strobe_in
phy_blocks  out  BLK_W  registered num_blocks
phy_write_read  out  1  registered write_read
phy_multiple  out  1  1 when num_blocks > 1
phy_timeout  out  TMO_W  registered timeout_val
phy_ack  out  1  one-cycle acknowledge after each completed block
phy_idle  out  1  high when no transfer is active
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end (success or error)
error  out  1  sticky; cleared by the next accepted start
blocks_done  out  BLK_W  count of successfully completed blocks

Behaviour:
- Reset:
  - All outputs 0 except phy_idle = 1.
  - State IDLE; counters 0.
  - Reset mid-transfer aborts immediately; no done pulse.
- States: IDLE, SETUP, WAIT_FIFO, STROBE, WAIT_PHY, ACK, DONE.
- IDLE:
  - start = 1 latches the inputs, clears error and blocks_done, goes to SETUP.
  - busy = 1 and phy_idle = 0 from the next cycle.
- SETUP: one cycle; phy_* config outputs become valid here.
  - num_blocks = 0: set error, go to DONE; no strobe issued.
- WAIT_FIFO: wait for fifo_ready.
  - Watchdog counts cycles in this state.
  - Count reaching timeout_val: set error, go to DONE.
  - timeout_val = 0 disables the watchdog.
- STROBE: phy_strobe = 1 for exactly one cycle, then WAIT_PHY.
  - Latency: start at cycle N with fifo_ready held high gives phy_strobe at N+3.
- WAIT_PHY:
  - phy_error: set error, go to DONE.
  - phy_complete: blocks_done++, go to ACK.
  - Both in the same cycle: error wins.
- ACK: phy_ack = 1 for one cycle.
  - blocks_done == num_blocks: go to DONE.
  - Otherwise: return to WAIT_FIFO.
- DONE: done = 1 for one cycle, busy = 0, phy_idle = 1, return to IDLE.
- start while busy is ignored; latched config does not change.
- phy_complete/phy_error outside WAIT_PHY are ignored.
- blocks_done saturates at num_blocks. No wrap at the 4'hF maximum: 15 blocks complete normally.

Optional Feature:
SD_DAT_CTRL_RETRY_EN
- Defined: phy_error in WAIT_PHY increments a per-block retry counter and returns to WAIT_FIFO to re-strobe the same block. error is set only when retries exceed MAX_RETRY. The retry counter clears on each phy_complete.
- Undefined: the first phy_error ends the transfer with error; no retry logic is synthesized.

Decomposition:
- Shared package sd_dat_defs: state encoding constants, BLK_W/TMO_W defaults, default timeout (16'd100).
- One sub-module sd_watchdog_cnt: loadable TMO_W-bit up-counter with clear and expire flag. Used for the WAIT_FIFO watchdog.

Test Plan:
- Single write: start, write_read=1, num_blocks=1, timeout=100, fifo_ready=1, phy_complete 20 cycles after strobe -> one phy_strobe at N+3, phy_multiple=0, phy_ack one cycle, done pulse, blocks_done=1, error=0.
- Multi read: num_blocks=3, write_read=0, phy_complete after each strobe -> 3 strobes, phy_multiple=1, 3 acks, blocks_done=3, single done pulse.
- FIFO stall: num_blocks=2, fifo_ready low for 150 cycles before block 2, timeout=100 -> error=1 after 100 cycles in WAIT_FIFO, done pulse, blocks_done=1.
- Error priority: phy_error and phy_complete asserted together -> error=1, done pulse, no phy_ack. With SD_DAT_CTRL_RETRY_EN instead: re-strobe; third consecutive error sets error.
- Zero blocks and ignored start: num_blocks=0 -> done and error with no strobe. A second start pulse mid-transfer leaves phy_blocks unchanged.
- Reset mid-op: assert reset in WAIT_PHY -> next cycle busy=0, phy_idle=1, blocks_done=0, no done pulse.

Source files
------------

// File: rtl/sd_dat_defs.sv
// Shared definitions for the SD DAT transfer sequencer: default widths, default timeout and
// the sequencer state encoding.
package sd_dat_defs;

    localparam int unsigned BLK_W_DEF   = 4;
    localparam int unsigned TMO_W_DEF   = 16;
    localparam logic [15:0] TMO_DEFAULT = 16'd100;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSetup    = 3'd1,
        StWaitFifo = 3'd2,
        StStrobe   = 3'd3,
        StWaitPhy  = 3'd4,
        StAck      = 3'd5,
        StDone     = 3'd6
    } xfer_state_e;

endpackage

// File: rtl/sd_watchdog_cnt.sv
// Loadable up-counter watchdog: counts cycles while enabled and flags when the loaded limit is
// reached. A limit of zero never expires.
module sd_watchdog_cnt #(
    parameter int unsigned TMO_W = 16
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMO_W-1:0] load_val,
    input  logic             clear,
    input  logic             enable,
    output logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] limit_q;
    logic [TMO_W-1:0] count_q;

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            limit_q <= '0;
            count_q <= '0;
        end else begin
            if (load) begin
                limit_q <= load_val;
            end
            if (clear) begin
                count_q <= '0;
            end else if (enable && (count_q != '1)) begin
                count_q <= count_q + TMO_W'(1);
            end
        end
    end

    // count_q holds the cycles already spent, so the current cycle is number count_q + 1.
    assign limit  = limit_q;
    assign expire = enable && (limit_q != '0) && (count_q == limit_q - TMO_W'(1));

endmodule

// File: rtl/sd_dat_xfer_ctrl.sv
// Transaction sequencer between host registers/FIFO and dat_phys in the SD clock domain.
// Optional per-block retry on phy_error is enabled by defining SD_DAT_CTRL_RETRY_EN.
module sd_dat_xfer_ctrl
    import sd_dat_defs::*;
#(
    parameter int unsigned BLK_W     = BLK_W_DEF,
    parameter int unsigned TMO_W     = TMO_W_DEF,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             write_read,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic [TMO_W-1:0] timeout_val,
    input  logic             fifo_ready,
    input  logic             phy_complete,
    input  logic             phy_error,
    output logic             phy_strobe,
    output logic [BLK_W-1:0] phy_blocks,
    output logic             phy_write_read,
    output logic             phy_multiple,
    output logic [TMO_W-1:0] phy_timeout,
    output logic             phy_ack,
    output logic             phy_idle,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [BLK_W-1:0] blocks_done
);

    xfer_state_e      state_q, state_d;
    logic [BLK_W-1:0] blocks_q;
    logic [BLK_W-1:0] done_cnt_q;
    logic             wr_q;
    logic             multiple_q;
    logic             error_q;
    logic             accept;
    logic             set_err;
    logic             blk_inc;
    logic             wd_expire;

`ifdef SD_DAT_CTRL_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_q;
    logic               retry_inc;
`endif

    assign accept = (state_q == StIdle) && start;

    sd_watchdog_cnt #(
        .TMO_W(TMO_W)
    ) u_fifo_wd (
        .sd_clock(sd_clock),
        .reset   (reset),
        .load    (accept),
        .load_val(timeout_val),
        .clear   (state_q != StWaitFifo),
        .enable  (state_q == StWaitFifo),
        .limit   (phy_timeout),
        .expire  (wd_expire)
    );

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        blk_inc = 1'b0;
`ifdef SD_DAT_CTRL_RETRY_EN
        retry_inc = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSetup;
            end
            StSetup: begin
                if (blocks_q == '0) begin
                    set_err = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StWaitFifo;
                end
            end
            StWaitFifo: begin
                if (fifo_ready) begin
                    state_d = StStrobe;
                end else if (wd_expire) begin
                    set_err = 1'b1;
                    state_d = StDone;
                end
            end
            StStrobe: state_d = StWaitPhy;
            StWaitPhy: begin
                // An error in the same cycle as a completion takes precedence.
                if (phy_error) begin
`ifdef SD_DAT_CTRL_RETRY_EN
                    if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        set_err = 1'b1;
                        state_d = StDone;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = StWaitFifo;
                    end
`else
                    set_err = 1'b1;
                    state_d = StDone;
`endif
                end else if (phy_complete) begin
                    blk_inc = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = (done_cnt_q == blocks_q) ? StDone : StWaitFifo;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            blocks_q   <= '0;
            wr_q       <= 1'b0;
            multiple_q <= 1'b0;
            error_q    <= 1'b0;
            done_cnt_q <= '0;
        end else if (accept) begin
            blocks_q   <= num_blocks;
            wr_q       <= write_read;
            multiple_q <= (num_blocks > BLK_W'(1));
            error_q    <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            if (set_err) begin
                error_q <= 1'b1;
            end
            if (blk_inc && (done_cnt_q != blocks_q)) begin
                done_cnt_q <= done_cnt_q + BLK_W'(1);
            end
        end
    end

`ifdef SD_DAT_CTRL_RETRY_EN
    always_ff @(posedge sd_clock) begin
        if (reset || accept || blk_inc) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + RETRY_W'(1);
        end
    end
`endif

    always_comb begin
        phy_strobe = (state_q == StStrobe);
        phy_ack    = (state_q == StAck);
        done       = (state_q == StDone);
        busy       = (state_q != StIdle) && (state_q != StDone);
        phy_idle   = !busy;
    end

    assign phy_blocks     = blocks_q;
    assign phy_write_read = wr_q;
    assign phy_multiple   = multiple_q;
    assign error          = error_q;
    assign blocks_done    = done_cnt_q;

endmodule

// File: tb/tb_sd_dat_xfer_ctrl.sv
// Self-checking bench for sd_dat_xfer_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a transaction-level model.
module tb_sd_dat_xfer_ctrl;

    localparam int MAX_RETRY = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic        write_read;
    logic [3:0]  num_blocks;
    logic [15:0] timeout_val;
    logic        fifo_ready;
    logic        phy_complete;
    logic        phy_error;
    logic        phy_strobe;
    logic [3:0]  phy_blocks;
    logic        phy_write_read;
    logic        phy_multiple;
    logic [15:0] phy_timeout;
    logic        phy_ack;
    logic        phy_idle;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  blocks_done;

    sd_dat_xfer_ctrl #(
        .BLK_W    (4),
        .TMO_W    (16),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sd_clock      (clk),
        .reset         (reset),
        .start         (start),
        .write_read    (write_read),
        .num_blocks    (num_blocks),
        .timeout_val   (timeout_val),
        .fifo_ready    (fifo_ready),
        .phy_complete  (phy_complete),
        .phy_error     (phy_error),
        .phy_strobe    (phy_strobe),
        .phy_blocks    (phy_blocks),
        .phy_write_read(phy_write_read),
        .phy_multiple  (phy_multiple),
        .phy_timeout   (phy_timeout),
        .phy_ack       (phy_ack),
        .phy_idle      (phy_idle),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .blocks_done   (blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic        e_strobe, e_ack, e_done, e_busy, e_idle, e_err, e_wr, e_mult;
    logic [3:0]  e_bd, e_blocks;
    logic [15:0] e_tmo;
    logic        s_rst, s_start, s_wr, s_fifo, s_cmp, s_err;
    logic [3:0]  s_nb;
    logic [15:0] s_tmo;

    task automatic set_reset_exp();
        e_strobe = 0; e_ack = 0; e_done = 0; e_busy = 0; e_idle = 1;
        e_err = 0; e_wr = 0; e_mult = 0; e_bd = 0; e_blocks = 0; e_tmo = 0;
    endtask

    // Advance one clock; inputs are sampled as the DUT sees them at that edge.
    task automatic tick();
        @(posedge clk);
        s_rst = reset; s_start = start; s_wr = write_read; s_nb = num_blocks;
        s_tmo = timeout_val; s_fifo = fifo_ready; s_cmp = phy_complete; s_err = phy_error;
        if (s_rst) set_reset_exp();
    endtask

    task automatic end_xfer(input bit err);
        if (err) e_err = 1;
        e_done = 1; e_busy = 0; e_idle = 1;
        tick();
        e_done = 0;
    endtask

    task automatic run_xfer();
        int unsigned waited;
        int          retries;
        bit          failed;
        e_blocks = s_nb; e_wr = s_wr; e_mult = (s_nb > 1); e_tmo = s_tmo;
        e_err = 0; e_bd = 0; e_busy = 1; e_idle = 0;
        tick();
        if (s_rst) return;
        if (e_blocks == 0) begin
            end_xfer(1);
            return;
        end
        retries = 0;
        while (1) begin
            waited = 0;
            while (1) begin
                tick();
                if (s_rst) return;
                waited++;
                if (s_fifo) break;
                if (e_tmo != 0 && waited == e_tmo) begin
                    end_xfer(1);
                    return;
                end
            end
            e_strobe = 1;
            tick();
            e_strobe = 0;
            if (s_rst) return;
            failed = 0;
            while (1) begin
                tick();
                if (s_rst) return;
                if (s_err) begin
                    failed = 1;
                    break;
                end
                if (s_cmp) break;
            end
            if (failed) begin
`ifdef SD_DAT_CTRL_RETRY_EN
                if (retries < MAX_RETRY) begin
                    retries++;
                    continue;
                end
`endif
                end_xfer(1);
                return;
            end
            retries = 0;
            e_bd = e_bd + 1;
            e_ack = 1;
            tick();
            e_ack = 0;
            if (s_rst) return;
            if (e_bd == e_blocks) begin
                end_xfer(0);
                return;
            end
        end
    endtask

    initial begin : model
        set_reset_exp();
        forever begin
            e_strobe = 0; e_ack = 0; e_done = 0; e_busy = 0; e_idle = 1;
            tick();
            if (!s_rst && s_start) run_xfer();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phy_strobe", int'(phy_strobe), int'(e_strobe));
            chk("phy_ack", int'(phy_ack), int'(e_ack));
            chk("done", int'(done), int'(e_done));
            chk("busy", int'(busy), int'(e_busy));
            chk("phy_idle", int'(phy_idle), int'(e_idle));
            chk("error", int'(error), int'(e_err));
            chk("blocks_done", int'(blocks_done), int'(e_bd));
            chk("phy_blocks", int'(phy_blocks), int'(e_blocks));
            chk("phy_write_read", int'(phy_write_read), int'(e_wr));
            chk("phy_multiple", int'(phy_multiple), int'(e_mult));
            chk("phy_timeout", int'(phy_timeout), int'(e_tmo));
        end
    end

    // ---------------- event counters ----------------
    int tot_strobe = 0, tot_ack = 0, tot_done = 0;
    always @(negedge clk) begin
        tot_strobe += int'(phy_strobe);
        tot_ack    += int'(phy_ack);
        tot_done   += int'(done);
    end

    // ---------------- dat_phys responder ----------------
    int resp_delay = 5;
    int resp_kind  = 0;  // 0 complete, 1 error, 2 both
    bit rnd_resp   = 0;
    int pend       = 0;
    int kind_now   = 0;

    initial begin : responder
        phy_complete = 0;
        phy_error    = 0;
        forever begin
            @(negedge clk);
            phy_complete = 0;
            phy_error    = 0;
            if (phy_strobe) begin
                if (rnd_resp) begin
                    pend = $urandom_range(1, 4);
                    kind_now = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 2);
                end else begin
                    pend = resp_delay;
                    kind_now = resp_kind;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    phy_complete = (kind_now != 1);
                    phy_error    = (kind_now != 0);
                end
            end else if (rnd_resp && $urandom_range(0, 19) == 0) begin
                phy_complete = $urandom_range(0, 1) == 1;
                phy_error    = $urandom_range(0, 3) == 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input bit wr, input logic [3:0] nb, input logic [15:0] tmo,
                            output int t);
        write_read = wr; num_blocks = nb; timeout_val = tmo; start = 1; t = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_evt(input int which, input int bound, output int t, output bit ok);
        ok = 0; t = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((which == 0 && phy_strobe) || (which == 1 && phy_ack)) begin
                ok = 1; t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input int bound, input bit rnd, output int t, output bit ok);
        ok = 0; t = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1; t = cyc; start = 0;
                break;
            end
            if (rnd) begin
                fifo_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                num_blocks = 4'($urandom);
                write_read = 1'($urandom);
                timeout_val = 16'($urandom);
            end
        end
        start = 0;
    endtask

    int t0, t1, t2;
    bit ok;
    int b_s, b_a, b_d;
    logic [3:0]  nb;
    logic [15:0] tmo;

    task automatic snap();
        b_s = tot_strobe; b_a = tot_ack; b_d = tot_done;
    endtask

    initial begin : main
        reset = 1; start = 0; write_read = 0; num_blocks = 0; timeout_val = 0; fifo_ready = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset busy", int'(busy), 0);
        chk("reset phy_idle", int'(phy_idle), 1);
        chk("reset error", int'(error), 0);
        chk("reset blocks_done", int'(blocks_done), 0);
        reset = 0;
        @(negedge clk);

        // Single write block
        fifo_ready = 1; resp_delay = 20; resp_kind = 0;
        snap();
        do_start(1, 4'd1, sd_dat_defs::TMO_DEFAULT, t0);
        chk("single phy_multiple", int'(phy_multiple), 0);
        chk("single phy_write_read", int'(phy_write_read), 1);
        wait_evt(0, 10, t1, ok);
        chk("single strobe seen", int'(ok), 1);
        chk("single strobe latency", t1 - t0, 3);
        wait_done(100, 0, t2, ok);
        chk("single done seen", int'(ok), 1);
        chk("single done time", t2 - t1, 22);
        chk("single error", int'(error), 0);
        chk("single blocks_done", int'(blocks_done), 1);
        chk("model blocks_done", int'(e_bd), 1);
        repeat (2) @(negedge clk);
        chk("single strobes", tot_strobe - b_s, 1);
        chk("single acks", tot_ack - b_a, 1);
        chk("single dones", tot_done - b_d, 1);

        // Multi-block read
        resp_delay = 5;
        snap();
        do_start(0, 4'd3, 16'd100, t0);
        chk("multi phy_multiple", int'(phy_multiple), 1);
        chk("multi phy_blocks", int'(phy_blocks), 3);
        chk("multi phy_timeout", int'(phy_timeout), 100);
        wait_done(200, 0, t2, ok);
        chk("multi done seen", int'(ok), 1);
        chk("multi blocks_done", int'(blocks_done), 3);
        repeat (2) @(negedge clk);
        chk("multi strobes", tot_strobe - b_s, 3);
        chk("multi acks", tot_ack - b_a, 3);
        chk("multi dones", tot_done - b_d, 1);

        // FIFO stall before the second block trips the watchdog
        snap();
        do_start(1, 4'd2, 16'd100, t0);
        wait_evt(1, 50, t1, ok);
        chk("stall first ack", int'(ok), 1);
        fifo_ready = 0;
        wait_done(300, 0, t2, ok);
        chk("stall done seen", int'(ok), 1);
        chk("stall watchdog time", t2 - t1, 101);
        chk("stall error", int'(error), 1);
        chk("stall blocks_done", int'(blocks_done), 1);
        chk("model stall error", int'(e_err), 1);
        repeat (2) @(negedge clk);
        chk("stall strobes", tot_strobe - b_s, 1);
        fifo_ready = 1;

        // Error and complete in the same cycle
        resp_kind = 2; resp_delay = 3;
        snap();
        do_start(0, 4'd1, 16'd100, t0);
        wait_done(200, 0, t2, ok);
        chk("errprio done seen", int'(ok), 1);
        chk("errprio error", int'(error), 1);
        chk("errprio blocks_done", int'(blocks_done), 0);
        repeat (2) @(negedge clk);
        chk("errprio acks", tot_ack - b_a, 0);
`ifdef SD_DAT_CTRL_RETRY_EN
        chk("errprio strobes", tot_strobe - b_s, 3);
`else
        chk("errprio strobes", tot_strobe - b_s, 1);
`endif
        resp_kind = 0;

        // Zero blocks
        snap();
        do_start(1, 4'd0, 16'd100, t0);
        wait_done(20, 0, t2, ok);
        chk("zero done seen", int'(ok), 1);
        chk("zero done time", t2 - t0, 2);
        chk("zero error", int'(error), 1);
        repeat (2) @(negedge clk);
        chk("zero strobes", tot_strobe - b_s, 0);

        // Start while busy is ignored
        resp_delay = 10;
        snap();
        do_start(0, 4'd2, 16'd100, t0);
        wait_evt(0, 10, t1, ok);
        do_start(1, 4'd7, 16'd5, t1);
        chk("ignored phy_blocks", int'(phy_blocks), 2);
        chk("ignored phy_write_read", int'(phy_write_read), 0);
        wait_done(200, 0, t2, ok);
        chk("ignored done seen", int'(ok), 1);
        chk("ignored blocks_done", int'(blocks_done), 2);
        repeat (2) @(negedge clk);
        chk("ignored strobes", tot_strobe - b_s, 2);

        // Fifteen blocks complete without wrap
        resp_delay = 1;
        do_start(1, 4'd15, 16'd100, t0);
        wait_done(400, 0, t2, ok);
        chk("fifteen done seen", int'(ok), 1);
        chk("fifteen blocks_done", int'(blocks_done), 15);
        chk("fifteen error", int'(error), 0);
        repeat (2) @(negedge clk);

        // Reset while waiting on the phy
        resp_delay = 30;
        snap();
        do_start(0, 4'd1, 16'd100, t0);
        wait_evt(0, 10, t1, ok);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midreset busy", int'(busy), 0);
        chk("midreset phy_idle", int'(phy_idle), 1);
        chk("midreset blocks_done", int'(blocks_done), 0);
        repeat (40) @(negedge clk);
        chk("midreset dones", tot_done - b_d, 0);

        // Randomized transactions
        rnd_resp = 1;
        for (int k = 0; k < 40; k++) begin
            nb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0:       tmo = 16'd0;
                1:       tmo = 16'($urandom_range(1, 6));
                2:       tmo = 16'($urandom_range(7, 40));
                default: tmo = 16'd100;
            endcase
            fifo_ready = 1'($urandom_range(0, 1));
            do_start(1'($urandom), nb, tmo, t0);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 20)) begin
                    @(negedge clk);
                    fifo_ready = 1'($urandom);
                end
                reset = 1;
                @(negedge clk);
                reset = 0;
            end else begin
                wait_done(4000, 1, t2, ok);
                chk("random xfer done", int'(ok), 1);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        rnd_resp = 0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
